// File: rtl/steer_delay_seq.sv
// Steering-angle to per-mic delay table sequencer: sweeps the mic grid row-major,
// reads the dual-port location ROM and writes saturated delay sums.
// Optional STEER_START_SYNC_EN: start passes a 2-flop synchronizer + rising-edge detector.
module steer_delay_seq #(
    parameter int GRID    = 5,
    parameter int DELAY_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         angle_hori,
    input  logic [7:0]         angle_vert,
    output logic               rom_rd_en,
    output logic [8:0]         rom_addr_a,
    output logic [8:0]         rom_addr_b,
    input  logic [DELAY_W-1:0] rom_q_a,
    input  logic [DELAY_W-1:0] rom_q_b,
    output logic               dly_we,
    output logic [4:0]         dly_addr,
    output logic [DELAY_W-1:0] dly_data,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] LAST_IDX = 3'(GRID - 1);
    localparam logic [4:0] LAST_MIC = 5'(GRID * GRID - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t             state;
    logic [2:0]         col;
    logic [2:0]         row;
    logic [4:0]         mic;
    logic [7:0]         ang_h;
    logic [7:0]         ang_v;
    logic               start_req;
    logic [2:0]         col_nxt;
    logic [2:0]         row_nxt;
    logic [DELAY_W:0]   sum;
    logic [DELAY_W-1:0] sat_data;

`ifdef STEER_START_SYNC_EN
    logic start_s1;
    logic start_s2;
    logic start_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_s3 <= 1'b0;
        end else begin
            start_s1 <= start;
            start_s2 <= start_s1;
            start_s3 <= start_s2;
        end
    end

    assign start_req = start_s2 & ~start_s3;
`else
    assign start_req = start;
`endif

    // Negative angles mirror the grid index on that axis; magnitude clamps to 63.
    function automatic logic [8:0] mk_addr(input logic [2:0] idx, input logic [7:0] ang);
        logic [7:0] mag;
        logic [5:0] mag_c;
        logic [2:0] idx_eff;
        mag     = ang[7] ? (~ang + 8'd1) : ang;
        mag_c   = (mag > 8'd63) ? 6'd63 : mag[5:0];
        idx_eff = ang[7] ? (LAST_IDX - idx) : idx;
        return {idx_eff, mag_c};
    endfunction

    always_comb begin
        col_nxt = (col == LAST_IDX) ? 3'd0 : col + 3'd1;
        row_nxt = (col == LAST_IDX) ? row + 3'd1 : row;
    end

    assign sum      = {1'b0, rom_q_a} + {1'b0, rom_q_b};
    assign sat_data = sum[DELAY_W] ? {DELAY_W{1'b1}} : sum[DELAY_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            col        <= 3'd0;
            row        <= 3'd0;
            mic        <= 5'd0;
            ang_h      <= 8'd0;
            ang_v      <= 8'd0;
            rom_rd_en  <= 1'b0;
            rom_addr_a <= 9'd0;
            rom_addr_b <= 9'd0;
            dly_we     <= 1'b0;
            dly_addr   <= 5'd0;
            dly_data   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Data for the read issued last cycle is on rom_q now; write it back.
            dly_we <= rom_rd_en;
            if (rom_rd_en) begin
                dly_addr <= mic;
                dly_data <= sat_data;
            end
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start_req) begin
                        ang_h      <= angle_hori;
                        ang_v      <= angle_vert;
                        col        <= 3'd0;
                        row        <= 3'd0;
                        mic        <= 5'd0;
                        rom_rd_en  <= 1'b1;
                        rom_addr_a <= mk_addr(3'd0, angle_hori);
                        rom_addr_b <= mk_addr(3'd0, angle_vert);
                        busy       <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (mic == LAST_MIC) begin
                        rom_rd_en <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        col        <= col_nxt;
                        row        <= row_nxt;
                        mic        <= mic + 5'd1;
                        rom_addr_a <= mk_addr(col_nxt, ang_h);
                        rom_addr_b <= mk_addr(row_nxt, ang_v);
                    end
                end
                DRAIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_steer_delay_seq.sv
// Bench for steer_delay_seq: directed and random steering sweeps against an
// arithmetic reference of the delay table, plus restart, reset and start-hold cases.
module tb_steer_delay_seq;
    localparam int GRID    = 5;
    localparam int DELAY_W = 8;
    localparam int N       = GRID * GRID;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [7:0]         angle_hori;
    logic [7:0]         angle_vert;
    logic               rom_rd_en;
    logic [8:0]         rom_addr_a;
    logic [8:0]         rom_addr_b;
    logic [DELAY_W-1:0] rom_q_a;
    logic [DELAY_W-1:0] rom_q_b;
    logic               dly_we;
    logic [4:0]         dly_addr;
    logic [DELAY_W-1:0] dly_data;
    logic               busy;
    logic               done;

    int total = 0;
    int bad   = 0;

    logic               rom_mode;
    logic [DELAY_W-1:0] rom_const;
    logic [DELAY_W-1:0] exp_q[$];

    steer_delay_seq #(.GRID(GRID), .DELAY_W(DELAY_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .angle_hori (angle_hori),
        .angle_vert (angle_vert),
        .rom_rd_en  (rom_rd_en),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_q_a    (rom_q_a),
        .rom_q_b    (rom_q_b),
        .dly_we     (dly_we),
        .dly_addr   (dly_addr),
        .dly_data   (dly_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ROM content: (addr / 64) * 16 + (addr % 64), or a constant word.
    function automatic int rom_val(input int addr);
        return (addr / 64) * 16 + (addr % 64);
    endfunction

    assign rom_q_a = rom_mode ? rom_const : DELAY_W'(rom_val(int'(rom_addr_a)));
    assign rom_q_b = rom_mode ? rom_const : DELAY_W'(rom_val(int'(rom_addr_b)));

    function automatic int ref_mag(input logic [7:0] a);
        int s;
        s = int'($signed(a));
        if (s < 0) s = -s;
        return (s > 63) ? 63 : s;
    endfunction

    function automatic int ref_addr(input int idx, input logic [7:0] a);
        int e;
        e = ($signed(a) < 0) ? (GRID - 1 - idx) : idx;
        return e * 64 + ref_mag(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] h, input logic [7:0] v);
        int cnt;
        angle_hori = h;
        angle_vert = v;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cnt = 0;
        while (rom_rd_en !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        chk("accept_wait_expired", 32'(cnt < 10), 32'd1);
    endtask

    task automatic run_sweep(input logic [7:0] h, input logic [7:0] v, input bit repulse);
        int ea[N];
        int eb[N];
        int qa;
        int qb;
        int s;
        logic [DELAY_W-1:0] d;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            ea[i] = ref_addr(i % GRID, h);
            eb[i] = ref_addr(i / GRID, v);
            qa = rom_mode ? int'(rom_const) : rom_val(ea[i]);
            qb = rom_mode ? int'(rom_const) : rom_val(eb[i]);
            s  = qa + qb;
            exp_q.push_back(DELAY_W'((s > 255) ? 255 : s));
        end
        launch(h, v);
        for (int k = 0; k <= N + 2; k++) begin
            if (k == 1) begin
                angle_hori = 8'($urandom);
                angle_vert = 8'($urandom);
            end
            if (repulse && k == 5) start = 1'b1;
            if (repulse && k == 6) start = 1'b0;
            if (k < N) begin
                chk("rd_en", 32'(rom_rd_en), 32'd1);
                chk("addr_a", 32'(rom_addr_a), 32'(ea[k]));
                chk("addr_b", 32'(rom_addr_b), 32'(eb[k]));
                chk("busy_read", 32'(busy), 32'd1);
            end
            if (k >= 1 && k <= N) begin
                d = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                chk("dly_we", 32'(dly_we), 32'd1);
                chk("dly_addr", 32'(dly_addr), 32'(k - 1));
                chk("dly_data", 32'(dly_data), 32'(d));
            end else begin
                chk("dly_we_idle", 32'(dly_we), 32'd0);
            end
            if (k == N) begin
                chk("rd_en_drain", 32'(rom_rd_en), 32'd0);
                chk("busy_drain", 32'(busy), 32'd1);
            end
            if (k == N + 1) chk("busy_done", 32'(busy), 32'd0);
            chk("done", 32'(done), 32'(k == N + 1));
            @(negedge clk);
        end
        repeat (4) begin
            chk("no_extra_sweep", 32'(rom_rd_en), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, 32'(rom_rd_en), 32'd0);
        chk({tag, "_addr_a"}, 32'(rom_addr_a), 32'd0);
        chk({tag, "_addr_b"}, 32'(rom_addr_b), 32'd0);
        chk({tag, "_we"}, 32'(dly_we), 32'd0);
        chk({tag, "_dly_addr"}, 32'(dly_addr), 32'd0);
        chk({tag, "_dly_data"}, 32'(dly_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int first;
        int rises;
        int dones;
        logic prev;

        rst_n      = 1'b0;
        start      = 1'b0;
        angle_hori = 8'd0;
        angle_vert = 8'd0;
        rom_mode   = 1'b0;
        rom_const  = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed angle cases, including mirroring and magnitude clamp.
        run_sweep(8'd3, 8'd2, 1'b0);
        run_sweep(8'hFD, 8'd0, 1'b0);
        run_sweep(8'h80, 8'h41, 1'b0);
        run_sweep(8'hC1, 8'h7F, 1'b0);

        // Saturation boundary and a non-saturating constant.
        rom_mode  = 1'b1;
        rom_const = 8'd200;
        run_sweep(8'd10, 8'd20, 1'b0);
        rom_const = 8'd100;
        run_sweep(8'hF0, 8'd5, 1'b0);
        rom_const = 8'd128;
        run_sweep(8'd0, 8'd0, 1'b0);
        rom_mode = 1'b0;

        // Random angles.
        repeat (5) run_sweep(8'($urandom), 8'($urandom), 1'b0);

        // Start re-pulsed mid-sweep is dropped.
        run_sweep(8'd7, 8'hF9, 1'b1);

        // Asynchronous reset mid-sweep, then a clean full sweep.
        launch(8'd4, 8'd4);
        repeat (10) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) begin
            @(negedge clk);
            chk("midreset_no_done", 32'(done), 32'd0);
            chk("midreset_no_rd", 32'(rom_rd_en), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep(8'hFE, 8'd9, 1'b0);

        // Start held high for 40 cycles.
        angle_hori = 8'd1;
        angle_vert = 8'd1;
        first = -1;
        rises = 0;
        dones = 0;
        prev  = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            @(negedge clk);
            if (rom_rd_en && !prev) begin
                rises++;
                if (first < 0) first = c;
            end
            prev = rom_rd_en;
            if (done) dones++;
            if (c == 40) start = 1'b0;
        end
`ifdef STEER_START_SYNC_EN
        chk("held_first_rd", 32'(first), 32'd3);
        chk("held_sweeps", 32'(rises), 32'd1);
        chk("held_dones", 32'(dones), 32'd1);
`else
        chk("held_first_rd", 32'(first), 32'd1);
        chk("held_sweeps", 32'(rises), 32'd2);
        chk("held_dones", 32'(dones), 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
